servo_pwm_driver: RTL and testbench
===================================

SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide TICK_DIV, 200, clk cycles per PWM tick (4 us at 50 MHz).
REQ-002 SHALL provide MIN_TICKS, 250, ticks of high time at position 0 (1.0 ms).
REQ-003 SHALL provide PERIOD_TICKS, 5000, ticks per PWM frame (20 ms).
REQ-004 SHALL provide SLEW, 4, maximum position change per channel per frame.
REQ-005 SHALL provide INIT_POS, 128, reset value of every channel's current position.
Ports (name, direction, width, meaning):
REQ-006 SHALL provide clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-008 SHALL provide enable, input, 1, PWM output enable, sampled at frame start.
REQ-009 SHALL provide dx, dy, dz, dg, input, 8 each, target positions from the coordinate controller, unsigned 0..255.
REQ-010 SHALL provide servo1, servo2, servo3, servo4, output, 1 each, registered PWM for the X, Y, Z and G channels.
REQ-011 SHALL provide frame_start, output, 1, one-clk pulse marking the first cycle of each frame.

Function
REQ-012 SHALL count clk cycles 0..TICK_DIV-1 in a prescaler and emit one tick when it wraps to 0.
REQ-013 SHALL count ticks in a frame counter 0..PERIOD_TICKS-1, wrapping to 0; frame period SHALL be exactly PERIOD_TICKS*TICK_DIV clks.
REQ-014 SHALL, on the frame boundary (prescaler 0 and frame counter 0), sample dx..dg into target shadow registers and sample enable into frame_en; inputs SHALL be ignored at all other times.
REQ-015 SHALL, on the same boundary, update each current position cur_n: |target-cur| <= SLEW -> cur = target; target > cur -> cur + SLEW; target < cur -> cur - SLEW.
REQ-016 SHALL compute slew in 9-bit signed width so that no wrap past 0 or 255 occurs.
REQ-017 SHALL leave cur_n unchanged on a boundary where enable is sampled low.
REQ-018 SHALL drive servo_n high while frame_en=1 and frame counter < MIN_TICKS + cur_n, low otherwise; comparison SHALL use a 13-bit width minimum.
REQ-019 SHALL make each servo_n high for exactly (MIN_TICKS+cur_n)*TICK_DIV clks per enabled frame, with the rising edge 1 clk after the boundary and all channels rising in the same clk.
REQ-020 SHALL assert frame_start for exactly 1 clk, coincident with the servo rising edge.
REQ-021 SHALL hold cur_n constant for the entire frame; target changes mid-frame SHALL affect only the next frame.
REQ-022 SHALL keep all servo_n low for the whole frame when frame_en=0; frame_start SHALL still pulse.
REQ-023 SHALL require MIN_TICKS+255 < PERIOD_TICKS, SLEW >= 1 and TICK_DIV >= 1; other values are unsupported.

Reset
REQ-024 SHALL, while rst=1, set prescaler=0, frame counter=0, cur_n=INIT_POS, targets=INIT_POS, frame_en=0, servo1..4=0 and frame_start=0.
REQ-025 SHALL treat the first clk with rst=0 as a frame boundary, so the first frame_start occurs 1 clk after reset release.
REQ-026 SHALL abort any frame in progress when rst asserts mid-pulse, with outputs low on the next clk.

Verification (TICK_DIV=2, MIN_TICKS=4, PERIOD_TICKS=300, SLEW=4, INIT_POS=128)
REQ-027 SHALL cover: reset release, enable=1, d*=128 held -> frame_start every 600 clks, every servo high exactly 264 clks per frame.
REQ-028 SHALL cover: dx steps 128->140 -> servo1 high widths 272, 280, 288, then 288 steady (3 frames, last step clipped to the target).
REQ-029 SHALL cover: dy=0 from cur 2 and dz=255 from cur 253 -> cur_y 0 (width 8), cur_z 255 (width 518), with no wrap.
REQ-030 SHALL cover: dg changed mid-frame -> current frame width unchanged, new slewed width starting at the next frame_start.
REQ-031 SHALL cover: enable=0 sampled at a boundary -> all servos low for 600 clks, cur unchanged, and the next enabled frame resumes the prior width.
REQ-032 SHALL cover: rst pulsed mid-pulse -> outputs low the next clk, widths back to 264, and frame_start 1 clk after release.

Source files
------------

// File: rtl/servo_pwm_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : servo_pwm_driver_if
// Brief   : Target-position inputs, enable and PWM outputs of the servo driver.
// Revision: 1.0 - initial release
// ============================================================================
interface servo_pwm_driver_if;
    logic       enable;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] dz;
    logic [7:0] dg;
    logic       servo1;
    logic       servo2;
    logic       servo3;
    logic       servo4;
    logic       frame_start;

    modport master (
        output enable, dx, dy, dz, dg,
        input  servo1, servo2, servo3, servo4, frame_start
    );

    modport slave (
        input  enable, dx, dy, dz, dg,
        output servo1, servo2, servo3, servo4, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : servo_pwm_driver
// Brief   : Four-channel hobby-servo PWM generator with per-frame slew limiting.
// Revision: 1.0 - initial release
// ============================================================================
module servo_pwm_driver #(
    parameter int TICK_DIV     = 200,
    parameter int MIN_TICKS    = 250,
    parameter int PERIOD_TICKS = 5000,
    parameter int SLEW         = 4,
    parameter int INIT_POS     = 128
) (
    input  wire logic          clk,
    input  wire logic          rst,
    servo_pwm_driver_if.slave  bus
);

    localparam int c_NCH   = 4;
    localparam int c_PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_FC_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam int c_CMP_W = (c_FC_W + 1 > 13) ? c_FC_W + 1 : 13;

    localparam logic [c_PS_W-1:0]  c_PS_LAST = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_FC_W-1:0]  c_FC_LAST = c_FC_W'(PERIOD_TICKS - 1);
    localparam logic [c_CMP_W-1:0] c_MIN     = c_CMP_W'(MIN_TICKS);
    localparam logic [7:0]         c_INIT    = 8'(INIT_POS);
    localparam logic [7:0]         c_STEP    = 8'(SLEW);
    localparam logic signed [8:0]  c_SLEW    = 9'(SLEW);

    logic [c_PS_W-1:0]         r_prescaler;
    logic [c_FC_W-1:0]         r_frameCnt;
    logic                      r_frameEn;
    logic                      r_frameStart;
    logic                      w_boundary;
    logic                      w_frameEnNext;
    logic [c_NCH-1:0][7:0]     w_din;
    logic [c_NCH-1:0]          w_servo;

    assign w_din         = {bus.dg, bus.dz, bus.dy, bus.dx};
    assign w_boundary    = (r_prescaler == '0) && (r_frameCnt == '0);
    assign w_frameEnNext = w_boundary ? bus.enable : r_frameEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler  <= '0;
            r_frameCnt   <= '0;
            r_frameEn    <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_frameEn    <= w_frameEnNext;
            r_frameStart <= w_boundary;
            if (r_prescaler == c_PS_LAST) begin
                r_prescaler <= '0;
                r_frameCnt  <= (r_frameCnt == c_FC_LAST) ? '0 : r_frameCnt + c_FC_W'(1);
            end else begin
                r_prescaler <= r_prescaler + c_PS_W'(1);
            end
        end
    end

    for (genvar i = 0; i < c_NCH; i++) begin : g_ch
        logic [7:0]        r_target;
        logic [7:0]        r_cur;
        logic              r_servo;
        logic [7:0]        w_targetNext;
        logic [7:0]        w_curNext;
        logic signed [8:0] w_diff;

        // Slew uses the value sampled on this very boundary, so a new target
        // starts moving the servo in the frame that begins right after it.
        always_comb begin
            w_targetNext = w_boundary ? w_din[i] : r_target;
            w_diff       = $signed({1'b0, w_targetNext}) - $signed({1'b0, r_cur});
            w_curNext    = r_cur;
            if (w_boundary && w_frameEnNext) begin
                if (w_diff > c_SLEW) begin
                    w_curNext = r_cur + c_STEP;
                end else if (w_diff < -c_SLEW) begin
                    w_curNext = r_cur - c_STEP;
                end else begin
                    w_curNext = w_targetNext;
                end
            end
        end

        // Registered one cycle ahead: the pulse covers frame-count values
        // 0..MIN_TICKS+cur-1, delayed one clk so it rises with frame_start.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_target <= c_INIT;
                r_cur    <= c_INIT;
                r_servo  <= 1'b0;
            end else begin
                r_target <= w_targetNext;
                r_cur    <= w_curNext;
                r_servo  <= w_frameEnNext &&
                            (c_CMP_W'(r_frameCnt) < (c_MIN + c_CMP_W'(w_curNext)));
            end
        end

        assign w_servo[i] = r_servo;
    end

    assign bus.servo1      = w_servo[0];
    assign bus.servo2      = w_servo[1];
    assign bus.servo3      = w_servo[2];
    assign bus.servo4      = w_servo[3];
    assign bus.frame_start = r_frameStart;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_servo_pwm_driver
// Brief   : Scoreboard bench: per-frame expected pulse widths from a slew model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_servo_pwm_driver;

    localparam int TICK_DIV     = 2;
    localparam int MIN_TICKS    = 4;
    localparam int PERIOD_TICKS = 300;
    localparam int SLEW         = 4;
    localparam int INIT_POS     = 128;
    localparam int FRAME_CLKS   = PERIOD_TICKS * TICK_DIV;
    localparam int MAIN_FRAMES  = 60;

    typedef struct {
        int w [4];
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    servo_pwm_driver_if bus ();

    servo_pwm_driver #(
        .TICK_DIV     (TICK_DIV),
        .MIN_TICKS    (MIN_TICKS),
        .PERIOD_TICKS (PERIOD_TICKS),
        .SLEW         (SLEW),
        .INIT_POS     (INIT_POS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t expQ [$];
    int   checks      = 0;
    int   errors      = 0;
    int   framesDone  = 0;
    int   cur [4];
    int   tgt [4];
    bit   en;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int stepPos(input int c, input int t);
        if (t - c > SLEW) return c + SLEW;
        if (c - t > SLEW) return c - SLEW;
        return t;
    endfunction

    function automatic int clampPos(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Drive the values that the next boundary will sample and record what the
    // following frame must look like.
    task automatic applyFrame();
        exp_t e;
        bus.enable = en;
        bus.dx     = 8'(tgt[0]);
        bus.dy     = 8'(tgt[1]);
        bus.dz     = 8'(tgt[2]);
        bus.dg     = 8'(tgt[3]);
        for (int i = 0; i < 4; i++) begin
            if (en) cur[i] = stepPos(cur[i], tgt[i]);
            e.w[i] = en ? (MIN_TICKS + cur[i]) * TICK_DIV : 0;
        end
        expQ.push_back(e);
    endtask

    task automatic junkInputs();
        bus.enable = 1'($urandom_range(0, 1));
        bus.dx     = 8'($urandom);
        bus.dy     = 8'($urandom);
        bus.dz     = 8'($urandom);
        bus.dg     = 8'($urandom);
    endtask

    task automatic waitFrameStart();
        for (int n = 0; n < FRAME_CLKS + 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.frame_start) return;
        end
        check("frame_start_timeout", 0, 1);
    endtask

    task automatic planFrame(input int k);
        int sel;
        en = 1'b1;
        if (k <= 1) begin
            for (int i = 0; i < 4; i++) tgt[i] = 128;
        end else if (k <= 5) begin
            tgt[0] = 140;
        end else if (k <= 37) begin
            tgt[1] = 2;
            tgt[2] = 253;
        end else if (k <= 39) begin
            tgt[1] = 0;
            tgt[2] = 255;
        end else if (k == 40) begin
            tgt[3] = 200;
        end else if (k == 41) begin
            en = 1'b0;
            for (int i = 0; i < 4; i++) tgt[i] = $urandom_range(0, 255);
        end else if (k == 42) begin
            for (int i = 0; i < 4; i++) tgt[i] = cur[i];
        end else begin
            en = (k == MAIN_FRAMES) || ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 4; i++) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       tgt[i] = 0;
                    1:       tgt[i] = 255;
                    2:       tgt[i] = clampPos(cur[i] + $urandom_range(0, 10) - 5);
                    default: tgt[i] = $urandom_range(0, 255);
                endcase
            end
        end
    endtask

    task automatic checkOutputsLow(input string tag);
        check({tag, "_servo1"},      int'(bus.servo1), 0);
        check({tag, "_servo2"},      int'(bus.servo2), 0);
        check({tag, "_servo3"},      int'(bus.servo3), 0);
        check({tag, "_servo4"},      int'(bus.servo4), 0);
        check({tag, "_frame_start"}, int'(bus.frame_start), 0);
    endtask

    // Monitor: measures each frame between frame_start pulses.
    initial begin
        bit   inFrame = 1'b0;
        int   idx = 0;
        int   cnt [4];
        int   first [4];
        int   last [4];
        logic s [4];
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                inFrame = 1'b0;
                continue;
            end
            if (bus.frame_start) begin
                if (inFrame) begin
                    framesDone++;
                    check("frame_len", idx, FRAME_CLKS);
                    if (expQ.size() == 0) begin
                        check("scoreboard_empty", 0, 1);
                    end else begin
                        e = expQ.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            check($sformatf("width_servo%0d", i + 1), cnt[i], e.w[i]);
                            check($sformatf("shape_servo%0d", i + 1),
                                  int'((cnt[i] == 0) || (first[i] == 0 && last[i] + 1 == cnt[i])), 1);
                        end
                    end
                end
                inFrame = 1'b1;
                idx = 0;
                for (int i = 0; i < 4; i++) begin
                    cnt[i] = 0;
                    first[i] = -1;
                    last[i] = -1;
                end
            end
            if (inFrame) begin
                s[0] = bus.servo1;
                s[1] = bus.servo2;
                s[2] = bus.servo3;
                s[3] = bus.servo4;
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) begin
                        if (first[i] < 0) first[i] = idx;
                        last[i] = idx;
                        cnt[i]++;
                    end
                end
                idx++;
                if (idx > FRAME_CLKS + 100) begin
                    check("frame_len_timeout", idx, FRAME_CLKS);
                    inFrame = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Driver and reference model.
    initial begin
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tgt[i] = 128;
            cur[i] = INIT_POS;
        end
        bus.enable = 1'b1;
        bus.dx = 8'd128;
        bus.dy = 8'd128;
        bus.dz = 8'd128;
        bus.dg = 8'd128;
        repeat (3) @(posedge clk);
        #1;
        checkOutputsLow("reset");

        applyFrame();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_frame_start", int'(bus.frame_start), 1);
        check("release_servo1_rise", int'(bus.servo1), 1);

        for (int k = 1; k <= MAIN_FRAMES; k++) begin
            junkInputs();
            repeat ($urandom_range(1, 500)) @(posedge clk);
            #1;
            planFrame(k);
            applyFrame();
            waitFrameStart();
        end

        // Abort the last frame while every pulse is still high.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutputsLow("midreset");
        expQ.delete();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur[i] = INIT_POS;
            tgt[i] = 128;
        end
        applyFrame();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rerelease_frame_start", int'(bus.frame_start), 1);

        for (int k = 0; k < 2; k++) begin
            junkInputs();
            repeat ($urandom_range(1, 500)) @(posedge clk);
            #1;
            en = 1'b1;
            for (int i = 0; i < 4; i++) tgt[i] = 128;
            applyFrame();
            waitFrameStart();
        end
        waitFrameStart();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", expQ.size(), 0);
        check("frames_checked", framesDone, MAIN_FRAMES + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
